// File: rtl/simpletron_boot_ctrl_pkg.sv
// Shared definitions for the Simpletron boot/run sequencer: state encodings,
// default word/address widths and sizing helpers.
package simpletron_boot_ctrl_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_ADDR_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_RUN     = 3'd4,
    ST_HALTED  = 3'd5,
    ST_TIMEOUT = 3'd6,
    ST_FAIL    = 3'd7
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The phase index must reach both HOLD_CYCLES-1 and MEM_DEPTH.
  function automatic int idx_width(input int hold_cycles, input int mem_depth);
    return $clog2(max_int(hold_cycles, mem_depth) + 1);
  endfunction

endpackage

// File: rtl/simpletron_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module simpletron_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/simpletron_boot_ctrl.sv
// Boot/run sequencer for the Simpletron core: hold reset, copy the ROM image into
// core memory, release reset and supervise the run. Define SIMPLETRON_BOOT_VERIFY_EN
// to read the image back and compare it against the ROM before releasing the core.
module simpletron_boot_ctrl
  import simpletron_boot_ctrl_pkg::*;
#(
  parameter int WORD_W         = DEF_WORD_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int MEM_DEPTH      = 100,
  parameter int HOLD_CYCLES    = 5,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              core_reset,
  input  logic              core_halt,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              verify_err,
  output logic [CNT_W-1:0]  cycles
);

  localparam int                IDX_W     = idx_width(HOLD_CYCLES, MEM_DEPTH);
  localparam logic [IDX_W-1:0]  HOLD_LAST = IDX_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LOAD_LAST = IDX_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CYC_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic              idx_clr;
  logic              cyc_clr;
  logic              cyc_en;
  logic [ADDR_W-1:0] idx_addr;
  logic              mem_we_q;
  logic [ADDR_W-1:0] wr_addr_q;

  // Phase index: HOLD cycle count, then LOAD/VERIFY word index k.
  simpletron_sat_counter #(.W(IDX_W)) u_idx (
    .clk   (clk),
    .rst_n (reset),
    .clr   (idx_clr),
    .en    (1'b1),
    .q     (idx)
  );

  simpletron_sat_counter #(.W(CNT_W)) u_cycles (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cyc_clr),
    .en    (cyc_en),
    .q     (cycles)
  );

  // The final LOAD/VERIFY cycle only drains the read pipeline; the address holds.
  assign idx_addr = (idx >= LOAD_LAST) ? ADDR_LAST : ADDR_W'(idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_next = state;
    case (state)
      ST_IDLE, ST_HALTED, ST_TIMEOUT, ST_FAIL: begin
        if (start) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (idx == HOLD_LAST) state_next = ST_LOAD;
      end
      ST_LOAD: begin
`ifdef SIMPLETRON_BOOT_VERIFY_EN
        if (idx == LOAD_LAST) state_next = ST_VERIFY;
`else
        if (idx == LOAD_LAST) state_next = ST_RUN;
`endif
      end
      ST_VERIFY: begin
`ifdef SIMPLETRON_BOOT_VERIFY_EN
        if ((idx != '0) && (mem_rdata != rom_data)) state_next = ST_FAIL;
        else if (idx == LOAD_LAST)                  state_next = ST_RUN;
`else
        state_next = ST_IDLE;
`endif
      end
      ST_RUN: begin
        if (core_halt) begin
          state_next = ST_HALTED;
        end else if ((TIMEOUT_CYCLES != 0) && (cycles == CYC_LIMIT)) begin
          state_next = ST_TIMEOUT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Every phase change restarts the index; cycles counts only RUN cycles that stay in RUN.
  assign idx_clr = (state_next != state);
  assign cyc_clr = (state_next == ST_HOLD) && (state != ST_HOLD);
  assign cyc_en  = (state == ST_RUN) && (state_next == ST_RUN);

  // Write strobe lags the ROM address by one cycle to match the ROM read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_q  <= 1'b0;
      wr_addr_q <= '0;
    end else if ((state == ST_LOAD) && (idx < LOAD_LAST)) begin
      mem_we_q  <= 1'b1;
      wr_addr_q <= idx_addr;
    end else begin
      mem_we_q  <= 1'b0;
      wr_addr_q <= '0;
    end
  end

  always_comb begin
    core_reset = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    verify_err = 1'b0;
    rom_addr   = '0;
    mem_addr   = wr_addr_q;
    case (state)
      ST_HOLD: busy = 1'b1;
      ST_LOAD: begin
        busy     = 1'b1;
        rom_addr = idx_addr;
      end
      ST_VERIFY: begin
        busy     = 1'b1;
        rom_addr = idx_addr;
        mem_addr = idx_addr;
      end
      ST_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
      end
      ST_HALTED: begin
        done       = 1'b1;
        core_reset = 1'b0;
      end
      ST_TIMEOUT: timeout = 1'b1;
`ifdef SIMPLETRON_BOOT_VERIFY_EN
      ST_FAIL: verify_err = 1'b1;
`endif
      default: ;
    endcase
  end

  assign mem_we = mem_we_q;
  // rom_data is the ROM's registered output, forwarded only while writing.
  assign mem_wdata = mem_we_q ? rom_data : '0;

`ifndef SIMPLETRON_BOOT_VERIFY_EN
  logic rdata_unused;
  assign rdata_unused = ^mem_rdata;
`endif

endmodule

// File: tb/tb_simpletron_boot_ctrl.sv
// Scoreboard bench for simpletron_boot_ctrl: expected memory writes are queued at
// boot and popped by a write monitor; status outputs are checked directly.
module tb_simpletron_boot_ctrl;

  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 7;
  localparam int MEM_DEPTH = 8;
  localparam int HOLD      = 4;
  localparam int TMO       = 50;
`ifdef SIMPLETRON_BOOT_VERIFY_EN
  localparam int VERIFY_CYC = MEM_DEPTH + 1;
`else
  localparam int VERIFY_CYC = 0;
`endif
  localparam int EXP_PRE = HOLD + 1;
  localparam int EXP_RST = HOLD + (MEM_DEPTH + 1) + VERIFY_CYC;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              core_reset;
  logic              core_halt;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              verify_err;
  logic [31:0]       cycles;

  logic              start2;
  logic [ADDR_W-1:0] rom_addr2;
  logic [WORD_W-1:0] rom_data2;
  logic              mem_we2;
  logic [ADDR_W-1:0] mem_addr2;
  logic [WORD_W-1:0] mem_wdata2;
  logic [WORD_W-1:0] mem_rdata2;
  logic              core_reset2;
  logic              core_halt2;
  logic              busy2;
  logic              done2;
  logic              timeout2;
  logic              verify_err2;
  logic [2:0]        cycles2;

  logic [WORD_W-1:0] rom_img [0:MEM_DEPTH-1];
  logic [WORD_W-1:0] mem [0:127];
  logic              corrupt;
  wr_t               sb[$];
  wr_t               mon_exp;
  int                n_checks;
  int                n_errors;

  simpletron_boot_ctrl #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH),
    .HOLD_CYCLES(HOLD), .CNT_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_reset(core_reset), .core_halt(core_halt),
    .busy(busy), .done(done), .timeout(timeout), .verify_err(verify_err), .cycles(cycles)
  );

  // Small instance with a 3-bit counter and the watchdog disabled, for saturation.
  simpletron_boot_ctrl #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .MEM_DEPTH(2),
    .HOLD_CYCLES(1), .CNT_W(3), .TIMEOUT_CYCLES(0)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start2),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .core_reset(core_reset2), .core_halt(core_halt2),
    .busy(busy2), .done(done2), .timeout(timeout2), .verify_err(verify_err2), .cycles(cycles2)
  );

  assign rom_data2  = '0;
  assign mem_rdata2 = '0;
  assign core_halt2 = 1'b0;

  initial begin
    rom_img[0] = 16'h1009; rom_img[1] = 16'h200A; rom_img[2] = 16'h300B; rom_img[3] = 16'h4100;
    rom_img[4] = 16'h5A5A; rom_img[5] = 16'hA5A5; rom_img[6] = 16'h0FF0; rom_img[7] = 16'hF00F;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM and core memory models, both with one cycle of read latency.
  always @(posedge clk) begin
    rom_data <= (rom_addr < ADDR_W'(MEM_DEPTH)) ? rom_img[rom_addr[2:0]] : 16'hDEAD;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (corrupt && (mem_addr == 7'd5)) ? (mem[mem_addr] ^ 16'h0001) : mem[mem_addr];
  end

  // Write monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_exp = sb.pop_front();
        if ((mem_addr !== mon_exp.addr) || (mem_wdata !== mon_exp.data)) begin
          n_errors++;
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                   mem_addr, mem_wdata, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_image();
    wr_t w;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      w.addr = ADDR_W'(i);
      w.data = rom_img[i];
      sb.push_back(w);
    end
  endtask

  // Leaves the bench at the negedge of the first HOLD cycle.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full boot up to the first RUN cycle; noisy adds start pulses in HOLD and LOAD.
  task automatic boot(input bit noisy);
    int n_pre;
    int n_rst;
    int n_we;
    bit seen_we;
    push_image();
    pulse_start();
    check("hold_busy", busy, 1);
    check("hold_done_clear", done, 0);
    check("hold_timeout_clear", timeout, 0);
    check("hold_verify_clear", verify_err, 0);
    check("hold_cycles_clear", cycles, 0);
    n_pre = 0; n_rst = 0; n_we = 0; seen_we = 0;
    for (int i = 0; i < 100; i++) begin
      if (!core_reset) break;
      n_rst++;
      if (mem_we) begin
        seen_we = 1;
        n_we++;
      end else if (!seen_we) begin
        n_pre++;
      end
      start = noisy && ((n_rst == 2) || (n_rst == 8));
      @(negedge clk);
    end
    start = 1'b0;
    check("boot_cycles_before_write", n_pre, EXP_PRE);
    check("boot_reset_cycles", n_rst, EXP_RST);
    check("boot_write_count", n_we, MEM_DEPTH);
    check("boot_sb_drained", sb.size(), 0);
    check("run_entry_busy", busy, 1);
    check("run_entry_cycles", cycles, 0);
  endtask

  initial begin
    int n;
    n_checks = 0; n_errors = 0;
    reset = 1'b0; start = 1'b0; start2 = 1'b0; core_halt = 1'b0; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_core_reset", core_reset, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_flags", {busy, done, timeout, verify_err}, 4'b0000);
    check("rst_cycles", cycles, 0);
    reset = 1'b1;
    core_halt = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_halt_ignored", {done, busy, core_reset}, 3'b001);
    core_halt = 1'b0;

    // Boot, run 20 cycles with a stray start, then halt.
    boot(1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = (i == 5);
    end
    start = 1'b0;
    check("run_busy_after_start", busy, 1);
    check("run_cycles_20", cycles, 20);
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    check("halt_done", done, 1);
    check("halt_busy", busy, 0);
    check("halt_core_reset", core_reset, 0);
    repeat (3) @(negedge clk);
    check("halt_cycles_frozen", cycles, 20);
    check("halt_done_held", done, 1);

    // Restart from HALTED with start noise, then let the watchdog expire.
    boot(1'b1);
    n = 0;
    while (!timeout && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TMO + 1);
    check("timeout_flag", timeout, 1);
    check("timeout_core_reset", core_reset, 1);
    check("timeout_cycles", cycles, TMO);
    check("timeout_busy_done", {busy, done}, 2'b00);

    // Halt in the same cycle the limit is reached: halt wins.
    boot(1'b0);
    repeat (TMO) @(negedge clk);
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    check("tie_done", done, 1);
    check("tie_timeout", timeout, 0);
    check("tie_cycles", cycles, TMO);

    // Reset pulse in LOAD word 3 aborts everything.
    push_image();
    pulse_start();
    n = 0;
    while (!(busy && (rom_addr == 7'd3)) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_k3", rom_addr, 3);
    #2 reset = 1'b0;
    #1;
    check("abort_core_reset", core_reset, 1);
    check("abort_mem_we", mem_we, 0);
    check("abort_addrs", {rom_addr, mem_addr}, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    check("abort_flags", {busy, done, timeout, verify_err}, 4'b0000);
    check("abort_pending_writes", sb.size(), MEM_DEPTH - 3);
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_idle", {busy, core_reset, mem_we}, 3'b010);
    boot(1'b0);
    core_halt = 1'b1;
    @(negedge clk);
    core_halt = 1'b0;
    check("abort_rerun_done", done, 1);
    check("abort_rerun_cycles", cycles, 0);

`ifdef SIMPLETRON_BOOT_VERIFY_EN
    // Corrupted word 5 must be caught by the read-back.
    corrupt = 1'b1;
    push_image();
    pulse_start();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check("verify_fail_latency", n, HOLD + MEM_DEPTH + 1 + 7);
    check("verify_err_flag", verify_err, 1);
    check("verify_fail_core_reset", core_reset, 1);
    check("verify_fail_sb", sb.size(), 0);
    repeat (3) @(negedge clk);
    check("verify_fail_held", {verify_err, core_reset, busy}, 3'b110);
    corrupt = 1'b0;
    boot(1'b0);
    check("verify_clean_core_reset", core_reset, 0);
`endif

    // Saturating counter on the small instance, watchdog disabled.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (40) @(negedge clk);
    check("sat_cycles", cycles2, 3'd7);
    check("sat_still_running", {busy2, timeout2, core_reset2}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
